seq_detector_prog: RTL and testbench

Parametrised, run-time programmable successor to the fixed 5-bit Mealy sequence detector. Serially shifts qualified input bits into a history register and compares the newest cfg-length bits against a programmed pattern. Overlap/non-overlap and Mealy/Moore output are selectable. Also keeps a saturating match counter. Sits between the serial bit source and downstream event logic.

---
 rtl/seq_det_pkg.sv | 9 +
 rtl/seq_det_match.sv | 20 ++
 rtl/seq_detector_prog.sv | 75 +++++++
 tb/tb_seq_detector_prog.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, width helper and output-mode enum for the programmable sequence detector
package seq_det_pkg;
  localparam logic [7:0] DEF_PATTERN = 8'b0001_1010;
  localparam int DEF_LEN = 5;
  typedef enum logic {MEALY, MOORE} mode_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_det_match.sv
// seq_det_match: masked compare of {hist, din} against the low len bits of pattern; ports: en, din, hist, pattern, len, hist_cnt in, hit out
module seq_det_match #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4
) (
  input  logic               en,
  input  logic               din,
  input  logic [MAX_LEN-2:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [LEN_W-1:0]   hist_cnt,
  output logic               hit
);
  logic [MAX_LEN-1:0] seq, mask;
  always_comb begin
    seq = {hist, din};
    mask = ~({MAX_LEN{1'b1}} << len);
    hit = en && (hist_cnt >= len - LEN_W'(1)) && (((seq ^ pattern) & mask) == '0);
  end
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector; ports: clk, reset, din_valid/din stream, cfg_* load, cnt_clr in; dout, match_count, cfg_err out
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter int DEF_LEN = seq_det_pkg::DEF_LEN,
  localparam int LEN_W = seq_det_pkg::len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);
  import seq_det_pkg::*;
  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r, hist_cnt;
  logic               overlap_r, dout_q, hit, cfg_ok, load, shift;
  mode_t              moore_r;
  logic [MAX_LEN-2:0] hist;
  always_comb begin
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    load = cfg_load && cfg_ok;
    // an illegal load does not steal the data bit
    shift = din_valid && !load;
    dout = (moore_r == MOORE) ? dout_q : hit;
  end
  seq_det_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
    .en(shift),
    .din(din),
    .hist(hist),
    .pattern(pattern_r),
    .len(len_r),
    .hist_cnt(hist_cnt),
    .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_r <= DEF_PATTERN;
      len_r <= LEN_W'(DEF_LEN);
      overlap_r <= 1'b1;
      moore_r <= MEALY;
      hist <= '0;
      hist_cnt <= '0;
      dout_q <= 1'b0;
      match_count <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (load) begin
        pattern_r <= cfg_pattern;
        len_r <= cfg_len;
        overlap_r <= cfg_overlap;
        moore_r <= cfg_moore ? MOORE : MEALY;
        hist_cnt <= '0;
        dout_q <= 1'b0;
      end else begin
        dout_q <= hit;
        if (shift) begin
          hist <= {hist[MAX_LEN-3:0], din};
          hist_cnt <= (hit && !overlap_r) ? '0 : (hist_cnt == LEN_W'(MAX_LEN)) ? hist_cnt : hist_cnt + LEN_W'(1);
        end
      end
      match_count <= cnt_clr ? CNT_W'(hit) : (hit && match_count != '1) ? match_count + CNT_W'(1) : match_count;
    end
  end
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and random stimulus against a bit-queue reference model
module tb_seq_detector_prog;
  logic       clk, reset, din_valid, din, cfg_load, cfg_overlap, cfg_moore, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       dout0, err0, dout1, err1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_pat;
  int m_len, m_fresh, m_cnt0, m_cnt1;
  bit m_ov, m_moore, m_dq, m_err;
  bit m_q[$];

  seq_detector_prog u0 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore),
    .cnt_clr(cnt_clr), .dout(dout0), .match_count(cnt0), .cfg_err(err0)
  );
  seq_detector_prog #(.CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore),
    .cnt_clr(cnt_clr), .dout(dout1), .match_count(cnt1), .cfg_err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // the newest bit is din (age 0); older bits come from the queue of accepted bits
  function automatic bit model_hit(input bit v, input bit d, input bit legal);
    bit b;
    if (!v || legal || m_fresh + 1 < m_len) return 0;
    for (int i = 0; i < m_len; i++) begin
      if (i > m_q.size()) return 0;
      b = (i == 0) ? d : m_q[m_q.size() - i];
      if (b != m_pat[i]) return 0;
    end
    return 1;
  endfunction

  task automatic model_reset();
    m_pat = 8'b0001_1010; m_len = 5; m_ov = 1; m_moore = 0;
    m_fresh = 0; m_dq = 0; m_cnt0 = 0; m_cnt1 = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic step(input bit v, input bit d, input bit ld, input logic [7:0] p, input logic [3:0] l,
                      input bit ov, input bit mo, input bit clr);
    bit legal, h;
    din_valid = v; din = d; cfg_load = ld; cfg_pattern = p; cfg_len = l;
    cfg_overlap = ov; cfg_moore = mo; cnt_clr = clr;
    legal = ld && l >= 1 && l <= 8;
    @(negedge clk);
    h = model_hit(v, d, legal);
    check("dout0", dout0, m_moore ? m_dq : h);
    check("dout1", dout1, m_moore ? m_dq : h);
    check("count0", cnt0, m_cnt0);
    check("count1", cnt1, m_cnt1);
    check("cfg_err", err0, m_err);
    @(posedge clk);
    m_err = ld && !legal;
    if (legal) begin
      m_pat = p; m_len = l; m_ov = ov; m_moore = mo; m_fresh = 0; m_dq = 0;
    end else begin
      m_dq = h;
      if (v) begin
        m_q.push_back(d);
        if (m_q.size() > 16) void'(m_q.pop_front());
        m_fresh = (h && !m_ov) ? 0 : (m_fresh < 8 ? m_fresh + 1 : 8);
      end
    end
    m_cnt0 = clr ? int'(h) : (h && m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
    m_cnt1 = clr ? int'(h) : (h && m_cnt1 < 3) ? m_cnt1 + 1 : m_cnt1;
    #1;
  endtask

  task automatic send(input bit d);
    step(1, d, 0, 8'h00, 4'd0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 4'd0, 0, 0, 0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov, input bit mo);
    step(0, 0, 1, p, l, ov, mo, 0);
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic do_reset();
    din_valid = 0; cfg_load = 0; cnt_clr = 0; reset = 1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0;
  endtask

  initial begin
    logic [3:0] rl;
    clk = 0; reset = 1; din_valid = 0; din = 0; cfg_load = 0; cfg_pattern = 0;
    cfg_len = 0; cfg_overlap = 0; cfg_moore = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    do_reset();
    idle();
    send_seq(16'b11_0101_1010, 10);
    check("t1_count", cnt0, 2);
    load(8'b101, 3, 1, 0);
    send_seq(16'b10101, 5);
    load(8'b101, 3, 0, 0);
    send_seq(16'b10101, 5);
    check("t2_count", cnt0, 5);
    load(8'b11010, 5, 1, 1);
    for (int i = 9; i >= 0; i--) begin
      send(1'(16'b11_0101_1010 >> i));
      if (i % 3 == 0) idle();
    end
    idle();
    check("t3_count", cnt0, 7);
    load(8'h00, 0, 1, 0);
    idle();
    send_seq(16'b11010, 5);
    idle();
    send_seq(16'b110, 3);
    step(1, 1, 1, 8'b11010, 5, 1, 0, 0);
    send_seq(16'b10, 2);
    idle();
    check("t4_count", cnt0, 8);
    load(8'b1, 1, 1, 0);
    send_seq(16'b1011, 4);
    do_reset();
    for (int k = 0; k < 5; k++) send_seq(16'b11010, 5);
    check("t5_sat", cnt1, 3);
    send_seq(16'b1101, 4);
    step(1, 0, 0, 8'h00, 4'd0, 0, 0, 1);
    check("t5_clr0", cnt0, 1);
    check("t5_clr1", cnt1, 1);
    step(0, 0, 0, 8'h00, 4'd0, 0, 0, 1);
    send_seq(16'b1101, 4);
    do_reset();
    send(0);
    send_seq(16'b11010, 5);
    check("t6_count", cnt0, 1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        rl = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 8'($urandom), rl,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 0, 8'h00, 4'd0, 0, 0,
             $urandom_range(0, 40) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
